// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; mul/div take WIDTH cycles with busy high throughout.
// No backpressure: start is accepted only in IDLE, otherwise dropped; the controller holds start until busy falls.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     opb;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 last;

  always_comb begin
    rs_neg   = ~op_i[0] & rs_data_i[WIDTH-1];
    rt_neg   = ~op_i[0] & rt_data_i[WIDTH-1];
    rs_mag   = rs_neg ? -rs_data_i : rs_data_i;
    rt_mag   = rt_neg ? -rt_data_i : rt_data_i;
    mul_sum  = acc + (opb[0] ? mcand : '0);
    // acc holds {remainder, remaining dividend bits}; quotient bits shift in at the bottom
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? -mul_sum : mul_sum;
    quo_fix  = div_zero ? '1 : (neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
    rem_fix  = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    last     = (cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, rs_mag};
                opb      <= rt_mag;
                neg_q    <= rs_neg ^ rt_neg;
                neg_r    <= 1'b0;
                div_zero <= 1'b0;
                cnt      <= '0;
                state    <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                acc      <= {{WIDTH{1'b0}}, rs_mag};
                mcand    <= '0;
                opb      <= rt_mag;
                neg_q    <= rs_neg ^ rt_neg;
                neg_r    <= rs_neg;
                div_zero <= (rt_data_i == '0);
                cnt      <= '0;
                state    <= DIV;
              end
              OP_MTHI: hi_q <= rs_data_i;
              OP_MTLO: lo_q <= rs_data_i;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc   <= mul_sum;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            {hi_q, lo_q} <= prod_fix;
            done_q       <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            lo_q   <= quo_fix;
            hi_q   <= rem_fix;
            done_q <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: hand-computed HI/LO results, latency, pulses and reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_i      (op),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start = 1'b1; op = o; rs = a; rt = b;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    vt[0] = {3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[1] = {3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[2] = {3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = {3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vt[4] = {3'd3, 32'd55,       32'd0,        32'd55,       32'hFFFFFFFF};
    vt[5] = {3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[6] = {3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vt[7] = {3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[8] = {3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

    rst = 1'b0; start = 1'b0; op = 3'd7; rs = '0; rt = '0;
    repeat (3) tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    rst = 1'b1;
    tick();

    start = 1'b1; op = 3'd4; rs = 32'h1234;
    tick();
    start = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi busy", {31'd0, busy}, 32'd0);
    start = 1'b1; op = 3'd5; rs = 32'hABCD;
    tick();
    start = 1'b0;
    check("mtlo lo", lo, 32'hABCD);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    check("mtlo done", {31'd0, done}, 32'd0);
    start = 1'b1; op = 3'd6; rs = 32'h5555;
    tick();
    start = 1'b0;
    check("nop hi", hi, 32'h1234);
    check("nop lo", lo, 32'hABCD);
    check("nop busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, cyc);
      check($sformatf("v%0d cycles", i), cyc, 32'd32);
      check($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d hi", i), hi, vt[i].h);
      check($sformatf("v%0d lo", i), lo, vt[i].l);
      tick();
      check($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
    end

    // MTHI arriving mid-MULT must be dropped
    start = 1'b1; op = 3'd0; rs = 32'h00010000; rt = 32'h00030000;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 3'd4; rs = 32'hDEAD;
    tick();
    start = 1'b0;
    check("midop busy", {31'd0, busy}, 32'd1);
    check("midop hi hold", hi, 32'hFFFFFFF9);
    check("midop lo hold", lo, 32'hFFFFFFFF);
    cyc = 0;
    while (busy && cyc < 200) begin tick(); cyc++; end
    check("midop hi", hi, 32'd3);
    check("midop lo", lo, 32'd0);
    tick();

    // asynchronous reset in the middle of a MULTU
    start = 1'b1; op = 3'd1; rs = 32'd5; rt = 32'd6;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst hi", hi, 32'd0);
    check("arst lo", lo, 32'd0);
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("post rst busy", {31'd0, busy}, 32'd0);
    check("post rst done", {31'd0, done}, 32'd0);
    check("post rst lo", lo, 32'd0);
    run_op(3'd1, 32'd5, 32'd6, cyc);
    check("post rst cycles", cyc, 32'd32);
    check("post rst mul lo", lo, 32'd30);
    check("post rst mul hi", hi, 32'd0);
    tick();

    // back-to-back: DIVU held on start while MULTU runs
    start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd4;
    tick();
    op = 3'd3; rs = 32'd12; rt = 32'd5;
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    check("b2b first cycles", cyc, 32'd32);
    check("b2b first lo", lo, 32'd12);
    check("b2b first hi", hi, 32'd0);
    tick();
    start = 1'b0;
    check("b2b accept busy", {31'd0, busy}, 32'd1);
    check("b2b accept done", {31'd0, done}, 32'd0);
    cyc = 0;
    while (busy && cyc < 200) begin tick(); cyc++; end
    check("b2b second cycles", cyc, 32'd32);
    check("b2b second done", {31'd0, done}, 32'd1);
    check("b2b second lo", lo, 32'd2);
    check("b2b second hi", hi, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
